bm_mult_acc_unit: RTL and testbench

BM_MULT_ACC_UNIT -- requirements
Module: bm_mult_acc_unit

---
 rtl/bm_mult_acc_unit.sv | 106 ++++++++++
 tb/tb_bm_mult_acc_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bm_mult_acc_unit.sv
// bm_mult_acc_unit: GF(2) bitmatrix multiply-accumulate over k_eff beats per frame.
// Defining BM_ACC_IN_REG_EN inserts an input register stage, so each product is accumulated one cycle after its beat is accepted.
module bm_mult_acc_unit #(
  parameter int K_MAX = 128,
  parameter int K_MIN = 2,
  parameter int W = 4,
  parameter int PACKET_LENGTH = 2,
  parameter int CNT_W = $clog2(K_MAX + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [CNT_W-1:0]                    k_cfg,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [W-1:0][W-1:0]                 bitmatrix_cols,
  input  logic [W-1:0][PACKET_LENGTH-1:0]     data_packet,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [W-1:0][PACKET_LENGTH-1:0]     out_packet,
  output logic                                busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
  localparam logic [CNT_W-1:0] KMIN_C = CNT_W'(K_MIN);
  localparam logic [CNT_W-1:0] KMAX_C = CNT_W'(K_MAX);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt, keff_q, keff_d, k_clamp, k_cur;
  logic [W-1:0][PACKET_LENGTH-1:0] acc_q, acc_d, prod, op_data;
  logic [W-1:0][W-1:0] op_cols;
  logic accept, acc_en, acc_first, frame_done;

  assign accept = in_valid && in_ready;
  assign cnt_nxt = cnt_q + 1'b1;
  assign k_clamp = k_cfg < KMIN_C ? KMIN_C : (k_cfg > KMAX_C ? KMAX_C : k_cfg);
  assign k_cur = state_q == IDLE ? k_clamp : keff_q;
  assign out_valid = state_q == OUT;
  assign busy = state_q != IDLE;
  assign out_packet = acc_q;

`ifdef BM_ACC_IN_REG_EN
  logic v_q, first_q, last_q;
  logic [W-1:0][W-1:0] cols_q;
  logic [W-1:0][PACKET_LENGTH-1:0] data_q;
  assign in_ready = state_q != OUT && !(v_q && last_q);
  assign op_cols = cols_q;
  assign op_data = data_q;
  assign acc_en = v_q;
  assign acc_first = first_q;
  assign frame_done = v_q && last_q;
  // capture the accepted beat and its frame position for accumulation next cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= 1'b0;
      first_q <= 1'b0;
      last_q <= 1'b0;
      cols_q <= '0;
      data_q <= '0;
    end else begin
      v_q <= accept;
      if (accept) begin
        first_q <= state_q == IDLE;
        last_q <= cnt_nxt == k_cur;
        cols_q <= bitmatrix_cols;
        data_q <= data_packet;
      end
    end
  end
`else
  assign in_ready = state_q != OUT;
  assign op_cols = bitmatrix_cols;
  assign op_data = data_packet;
  assign acc_en = accept;
  assign acc_first = state_q == IDLE;
  assign frame_done = accept && cnt_nxt == k_cur;
`endif

  // product row j is the XOR of the data chunks selected by column j
  always_comb begin
    prod = '0;
    for (int j = 0; j < W; j++)
      for (int i = 0; i < W; i++)
        prod[j] = prod[j] ^ (op_data[i] & {PACKET_LENGTH{op_cols[j][i]}});
  end

  // next-state: count accepted beats, accumulate products, hold result until drained
  always_comb begin
    state_d = state_q == OUT ? (out_ready ? IDLE : OUT) : (frame_done ? OUT : (accept ? ACCUM : state_q));
    cnt_d = (state_q == OUT && out_ready) ? '0 : (accept ? cnt_nxt : cnt_q);
    keff_d = accept ? k_cur : keff_q;
    acc_d = acc_en ? (acc_first ? prod : acc_q ^ prod) : acc_q;
  end

  // state, counter, frame length and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      keff_q <= KMIN_C;
      acc_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      keff_q <= keff_d;
      acc_q <= acc_d;
    end
  end
endmodule

// File: tb/tb_bm_mult_acc_unit.sv
// tb_bm_mult_acc_unit: directed and random checks of bm_mult_acc_unit against a frame-level model.
module tb_bm_mult_acc_unit;
  typedef logic [3:0][1:0] pk_t;
  typedef logic [3:0][3:0] cm_t;
`ifdef BM_ACC_IN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam cm_t ID = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam cm_t ONES = '1;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [3:0] k_cfg = '0;
  cm_t bitmatrix_cols = '0;
  pk_t data_packet = '0, out_packet, last_out = '0;
  int checks = 0, failures = 0, hs = 0;

  bm_mult_acc_unit #(.K_MAX(8), .K_MIN(2), .W(4), .PACKET_LENGTH(2)) dut (
    .clk(clk), .rst(rst), .k_cfg(k_cfg), .in_valid(in_valid), .in_ready(in_ready),
    .bitmatrix_cols(bitmatrix_cols), .data_packet(data_packet), .out_valid(out_valid),
    .out_ready(out_ready), .out_packet(out_packet), .busy(busy));

  always #5 clk = ~clk;

  function automatic pk_t mk(int a, int b, int c, int d);
    pk_t r;
    r[0] = 2'(a); r[1] = 2'(b); r[2] = 2'(c); r[3] = 2'(d);
    return r;
  endfunction

  // per bit-plane GF(2) matrix-vector product: out[j][b] = parity(col j AND data bits at plane b)
  function automatic pk_t gf_prod(cm_t c, pk_t d);
    pk_t r = '0;
    for (int b = 0; b < 2; b++) begin
      logic [3:0] v;
      for (int i = 0; i < 4; i++) v[i] = d[i][b];
      for (int j = 0; j < 4; j++) r[j][b] = ^(c[j] & v);
    end
    return r;
  endfunction

  function automatic int clampk(logic [3:0] k);
    return k < 2 ? 2 : (k > 8 ? 8 : int'(k));
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask

  pk_t p_now;
  int kc_now;
  assign p_now = gf_prod(bitmatrix_cols, data_packet);
  assign kc_now = clampk(k_cfg);

  int m_cnt = 0, m_keff = 2;
  logic m_out = 1'b0, m_drain = 1'b0, started = 1'b0;
  pk_t m_acc = '0;

  // frame-level model: beats taken while not holding/draining a result
  always @(posedge clk) begin
    started <= 1'b1;
    if (rst) begin
      m_cnt <= 0; m_out <= 1'b0; m_drain <= 1'b0;
    end else if (m_out) begin
      if (out_ready) begin m_out <= 1'b0; m_cnt <= 0; end
    end else if (m_drain) begin
      m_drain <= 1'b0; m_out <= 1'b1;
    end else if (in_valid) begin
      m_acc <= m_cnt == 0 ? p_now : m_acc ^ p_now;
      if (m_cnt == 0) m_keff <= kc_now;
      m_cnt <= m_cnt + 1;
      if (m_cnt + 1 == (m_cnt == 0 ? kc_now : m_keff)) begin
        if (LAT == 2) m_drain <= 1'b1; else m_out <= 1'b1;
      end
    end
  end

  // compare DUT against model every cycle, mid-period
  always @(negedge clk) if (started) begin
    chk("in_ready", in_ready, !(m_out || m_drain));
    chk("out_valid", out_valid, m_out);
    chk("busy", busy, m_cnt != 0 || m_out);
    if (m_out) chk("out_packet", out_packet, m_acc);
    if (out_valid && out_ready) begin hs++; last_out = out_packet; end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic drive(logic v, pk_t d, cm_t c, logic [3:0] k);
    in_valid = v; data_packet = d; bitmatrix_cols = c; k_cfg = k;
    cyc();
  endtask

  task automatic idle(int n);
    in_valid = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    int n, beats;
    logic done;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_packet", out_packet, '0);
    cyc();
    drive(1, mk(1,2,3,0), ID, 2); drive(1, mk(3,3,0,1), ID, 2); idle(4);
    chk("r36_result", last_out, mk(2,1,3,1));
    chk("r36_hs", hs, 1);
    drive(1, mk(1,2,0,0), ONES, 2); drive(1, mk(0,0,0,0), ONES, 2); idle(4);
    chk("r37_result", last_out, mk(3,3,3,3));
    chk("r37_hs", hs, 2);
    out_ready = 1'b0;
    drive(1, mk(1,0,0,0), ID, 2); drive(1, mk(0,1,0,0), ID, 2); idle(7);
    chk("r38_held", hs, 2);
    out_ready = 1'b1; idle(2);
    chk("r38_hs", hs, 3);
    chk("r38_result", last_out, mk(1,1,0,0));
    drive(1, mk(1,0,0,0), ID, 0); drive(1, mk(1,0,0,0), ID, 0); idle(4);
    chk("r39_kmin", hs, 4);
    drive(1, mk(1,0,0,0), ID, 3); drive(1, mk(2,0,0,0), ID, 5); drive(1, mk(0,3,0,0), ID, 5); idle(4);
    chk("r39_ksample", hs, 5);
    chk("r39_result", last_out, mk(3,3,0,0));
    drive(1, mk(3,3,3,3), ID, 3); drive(1, mk(3,3,3,3), ID, 3);
    in_valid = 1'b0; rst = 1'b1; cyc(); rst = 1'b0; idle(4);
    chk("r40_nopulse", hs, 5);
    drive(1, mk(1,1,1,1), ID, 2); drive(1, mk(2,0,0,0), ID, 2); idle(4);
    chk("r40_result", last_out, mk(3,1,1,1));
    drive(1, mk(1,0,0,0), ID, 3); idle(2);
    drive(1, mk(0,2,0,0), ID, 3);
    in_valid = 1'b1; data_packet = mk(0,0,3,0); cyc();
    in_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 6);
    chk("r41_latency", n, LAT);
    idle(3);
    chk("r41_result", last_out, mk(1,2,3,0));
    in_valid = 1'b1; k_cfg = 4'd15; beats = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (out_valid) done = 1'b1;
      else if (in_ready) beats++;
      data_packet = pk_t'($urandom); bitmatrix_cols = cm_t'($urandom);
    end
    in_valid = 1'b0;
    chk("clamp_hi_beats", beats, 8);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      k_cfg = 4'($urandom);
      data_packet = pk_t'($urandom);
      bitmatrix_cols = cm_t'($urandom);
      cyc();
    end
    rst = 1'b0; out_ready = 1'b1; idle(12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
